// File: rtl/demux1x4_router.sv
// 1-to-4 packet demultiplexer: one-entry register per output channel, channel locked for a whole packet.
// Optional per-channel beat counters are enabled with the DEMUX_BEAT_COUNT_EN macro.
module demux1x4_router #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [1:0]          in_sel,
  input  logic                in_last,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic [3:0]          out_last,
  output logic                busy
`ifdef DEMUX_BEAT_COUNT_EN
  ,
  input  logic                cnt_clr,
  output logic [4*16-1:0]     beat_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [1:0]        lock_sel_r, lock_sel_s;
  logic [1:0]        active_sel_s;
  logic              in_xfer_s;
  logic [3:0]        out_xfer_s;
  logic [3:0]        load_s;
  logic [3:0]        valid_r;
  logic [3:0]        last_r;
  logic [DATA_W-1:0] data_r [4];

  // Handshake: the active channel can accept when empty or draining this cycle.
  always_comb begin
    active_sel_s = (state_r == ST_PKT) ? lock_sel_r : in_sel;
    in_ready     = ~valid_r[active_sel_s] | out_ready[active_sel_s];
    in_xfer_s    = in_valid & in_ready;
    out_xfer_s   = valid_r & out_ready;
    load_s       = 4'b0000;
    if (in_xfer_s) begin
      load_s[active_sel_s] = 1'b1;
    end else begin
      load_s = 4'b0000;
    end
  end

  // Next-state logic: a non-last first beat locks the channel until the last beat.
  always_comb begin
    state_s    = state_r;
    lock_sel_s = lock_sel_r;
    case (state_r)
      ST_IDLE: begin
        if (in_xfer_s && !in_last) begin
          state_s    = ST_PKT;
          lock_sel_s = in_sel;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_PKT: begin
        if (in_xfer_s && in_last) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_PKT;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        lock_sel_s = 2'd0;
      end
    endcase
  end

  // FSM state and locked channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      lock_sel_r <= 2'd0;
    end else begin
      state_r    <= state_s;
      lock_sel_r <= lock_sel_s;
    end
  end

  // Per-channel output registers; a load wins over a simultaneous drain so valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 4'b0000;
      last_r  <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_r[k] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load_s[k]) begin
          valid_r[k] <= 1'b1;
          data_r[k]  <= in_data;
          last_r[k]  <= in_last;
        end else if (out_xfer_s[k]) begin
          valid_r[k] <= 1'b0;
        end
      end
    end
  end

  // Output mapping of the channel registers.
  always_comb begin
    out_valid = valid_r;
    out_last  = last_r;
    busy      = (state_r == ST_PKT);
    out_data  = {(4*DATA_W){1'b0}};
    for (int k = 0; k < 4; k++) begin
      out_data[k*DATA_W +: DATA_W] = data_r[k];
    end
  end

`ifdef DEMUX_BEAT_COUNT_EN
  logic [15:0] cnt_r [4];

  // Completed output transfers per channel; clear has priority, counts wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt_r[k] <= 16'd0;
      end
    end else if (cnt_clr) begin
      for (int k = 0; k < 4; k++) begin
        cnt_r[k] <= 16'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (out_xfer_s[k]) begin
          cnt_r[k] <= cnt_r[k] + 16'd1;
        end
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    beat_cnt = {(4*16){1'b0}};
    for (int k = 0; k < 4; k++) begin
      beat_cnt[k*16 +: 16] = cnt_r[k];
    end
  end
`endif

endmodule
